// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// SPRAM_ARB_RR_EN (defined by the build) selects round-robin versus fixed-priority arbitration.
package spram_arb_pkg;

    localparam int unsigned DEF_DWIDTH = 8;
    localparam int unsigned DEF_AWIDTH = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // Requester that is preferred after `id` has been served.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/spram_arbiter_arb2_rr.sv
// Two-way grant logic. With SPRAM_ARB_RR_EN the last-served requester loses ties;
// without it req0 always wins ties and no pointer register exists.
module arb2_rr
    import spram_arb_pkg::*;
(
`ifdef SPRAM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       adv_i,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c_o,
    output logic       gnt_id_c_o
);

    logic prefer;

`ifdef SPRAM_ARB_RR_EN
    logic ptr_q;
    logic ptr_d;

    // Pointer moves only when a grant is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = other_req(gnt_id_c_o);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign prefer = ptr_q;
`else
    assign prefer = REQ0;
`endif

    // A lone requester wins outright; the preference only breaks ties.
    always_comb begin
        gnt_c_o    = 2'b00;
        gnt_id_c_o = prefer;
        if (req_i == 2'b01) begin
            gnt_id_c_o = REQ0;
        end else if (req_i == 2'b10) begin
            gnt_id_c_o = REQ1;
        end
        if (|req_i) begin
            gnt_c_o[gnt_id_c_o] = 1'b1;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter: serialises two valid/ready requesters onto one 1-cycle-read single-port RAM.
// Define SPRAM_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wen,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DWIDTH-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wen,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DWIDTH-1:0] rsp1_rdata,

    output logic              ram_en,
    output logic              ram_wen,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_datai,
    input  logic [DWIDTH-1:0] ram_datao
);

    arb_state_e        state_q;
    arb_state_e        state_d;

    logic [1:0]        req_valid;
    logic [1:0]        gnt;
    logic              gnt_id;
    logic              accept;

    logic              sel_wen;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;

    logic              cmd_id_q;
    logic              cmd_id_d;
    logic              ram_en_q;
    logic              ram_en_d;
    logic              ram_wen_q;
    logic              ram_wen_d;
    logic [AWIDTH-1:0] ram_addr_q;
    logic [AWIDTH-1:0] ram_addr_d;
    logic [DWIDTH-1:0] ram_datai_q;
    logic [DWIDTH-1:0] ram_datai_d;

    logic              rsp0_valid_q;
    logic              rsp0_valid_d;
    logic              rsp1_valid_q;
    logic              rsp1_valid_d;
    logic [DWIDTH-1:0] rsp0_rdata_q;
    logic [DWIDTH-1:0] rsp0_rdata_d;
    logic [DWIDTH-1:0] rsp1_rdata_q;
    logic [DWIDTH-1:0] rsp1_rdata_d;

    assign req_valid = {req1_valid, req0_valid};

    arb2_rr u_arb (
`ifdef SPRAM_ARB_RR_EN
        .clk        (clk),
        .rst        (rst),
        .adv_i      (accept),
`endif
        .req_i      (req_valid),
        .gnt_c_o    (gnt),
        .gnt_id_c_o (gnt_id)
    );

    // A command can only be taken while idle; the arbiter always has a winner if any valid is up.
    assign accept     = (state_q == IDLE) && (|req_valid);
    assign req0_ready = (state_q == IDLE) && gnt[REQ0];
    assign req1_ready = (state_q == IDLE) && gnt[REQ1];

    assign sel_wen   = (gnt_id == REQ1) ? req1_wen   : req0_wen;
    assign sel_addr  = (gnt_id == REQ1) ? req1_addr  : req0_addr;
    assign sel_wdata = (gnt_id == REQ1) ? req1_wdata : req0_wdata;

    // Next state plus output/datapath next values; RAM pins are nonzero only in ISSUE.
    always_comb begin
        state_d      = state_q;
        cmd_id_d     = cmd_id_q;
        ram_en_d     = 1'b0;
        ram_wen_d    = 1'b0;
        ram_addr_d   = '0;
        ram_datai_d  = '0;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = ISSUE;
                    cmd_id_d    = gnt_id;
                    ram_en_d    = 1'b1;
                    ram_wen_d   = sel_wen;
                    ram_addr_d  = sel_addr;
                    ram_datai_d = sel_wdata;
                end
            end
            ISSUE: begin
                state_d = ram_wen_q ? IDLE : RESP;
            end
            RESP: begin
                // RAM output register holds the read data during this cycle.
                state_d = IDLE;
                if (cmd_id_q == REQ1) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_rdata_d = ram_datao;
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_rdata_d = ram_datao;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_id_q     <= REQ0;
            ram_en_q     <= 1'b0;
            ram_wen_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_datai_q  <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_id_q     <= cmd_id_d;
            ram_en_q     <= ram_en_d;
            ram_wen_q    <= ram_wen_d;
            ram_addr_q   <= ram_addr_d;
            ram_datai_q  <= ram_datai_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign ram_en     = ram_en_q;
    assign ram_wen    = ram_wen_q;
    assign ram_addr   = ram_addr_q;
    assign ram_datai  = ram_datai_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule
